mul_shift_add: RTL and testbench
================================

# mul_shift_add

Sequential shift-and-add multiplier that feeds the 4-bit carry-lookahead adder slice, `cladder4`, once per cycle and consumes its sum and carry. It takes one WIDTH×WIDTH operand pair through a valid/ready handshake, iterates WIDTH add/shift steps, and presents a 2·WIDTH-bit product through a second valid/ready handshake. It sits between the operand register file and the result writeback path of the datapath.

## Interface
Parameters:
- WIDTH, default 4: operand width. Must be a multiple of 4. The adder is WIDTH/4 `cladder4` slices rippling Cout to Cin.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- in_valid, input, 1: operand pair offered.
- in_ready, output, 1: block can accept a pair. High only in IDLE.
- a, input, WIDTH: multiplicand.
- b, input, WIDTH: multiplier.
- out_valid, output, 1: product available. High only in DONE.
- out_ready, input, 1: downstream accepts the product.
- product, output, 2·WIDTH: result. Stable while out_valid is high.
- busy, output, 1: state is RUN.

## Operation
- Registers:
  - mcand: WIDTH bits.
  - acc_hi: WIDTH bits.
  - acc_lo: WIDTH bits. Holds the multiplier on load and the product low half at the end.
  - cnt: clog2(WIDTH+1) bits.
  - state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: mcand←a, acc_lo←b, acc_hi←0, cnt←WIDTH, go to RUN.
- RUN, one step per cycle:
  - sum,cout = acc_hi + (acc_lo[0] ? mcand : 0), with Cin=0.
  - {acc_hi, acc_lo} ← {cout, sum, acc_lo} >> 1.
  - cnt←cnt−1.
  - After the step taken with cnt==1, go to DONE.
- DONE:
  - out_valid=1, product={acc_hi, acc_lo}.
  - On out_ready, go to IDLE.
  - Without out_ready, hold all registers. Product must not change under backpressure.
- in_valid is ignored outside IDLE. Upstream holds its data until in_ready.
- Arithmetic is unsigned unless the signed option below is compiled in.
- The final carry is absorbed by the shift. The product never overflows 2·WIDTH bits.
- Reset mid-operation (rst_n low at any edge):
  - state←IDLE, every register←0.
  - The in-flight operation is discarded with no output.

## Timing
- Reset values:
  - in_ready=1 (IDLE).
  - out_valid=0, busy=0.
  - product=0.
- Accept at edge E0. busy is high for cycles E0+1 … E0+WIDTH.
- out_valid rises after edge E0+WIDTH+1? No: out_valid rises after edge E0+WIDTH, i.e. latency is WIDTH cycles from accept to out_valid.
- If out_ready is high in the first DONE cycle, in_ready is high on the next cycle.
- Peak throughput is one product per WIDTH+2 cycles.
- There is no accept in the same cycle as out_valid. in_ready and out_valid are mutually exclusive.
- in_ready, out_valid and busy are decoded from registered state only. No combinational path exists from in_valid or out_ready to any output.

## Configuration
- MUL_SHIFT_ADD_SIGNED_EN defined:
  - Operands are two's complement.
  - On accept, mcand and acc_lo load |a| and |b|. The most negative value maps to 2^(WIDTH−1), which still fits unsigned.
  - A neg flag ← a[MSB]^b[MSB] is registered.
  - In DONE, product = neg ? −{acc_hi,acc_lo} : {acc_hi,acc_lo}. The negation is combinational from registers.
  - Latency is unchanged.
- MUL_SHIFT_ADD_SIGNED_EN undefined:
  - Purely unsigned.
  - No neg register and no negation logic.

## Structure
- Shared package mul_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Localparam for default WIDTH.
  - Function computing the cnt width.
- One sub-module: `cladder4`, instantiated WIDTH/4 times inside a generate loop.
  - Only S and Cout are used. PG and GG are left unconnected.

## Test plan
- Unsigned, WIDTH=4, a=5, b=3, out_ready=1 → out_valid exactly 4 cycles after accept, product=8'h0F; in_ready high the following cycle.
- a=15, b=15 → product=8'hE1. The carry out of the adder is exercised on every step.
- a=0, b=9, then a=9, b=0 back-to-back → product=0 both times; second accept occurs exactly WIDTH+2 cycles after the first.
- Backpressure: a=7, b=6, out_ready low for 5 cycles after out_valid → product stays 8'h2A and in_ready stays 0 throughout; a single transfer on out_ready.
- Reset mid-run: rst_n low for one edge, 2 cycles after accepting a=12, b=11 → next cycle state is IDLE, in_ready=1, out_valid=0, product=0; no stale result appears afterwards.
- MUL_SHIFT_ADD_SIGNED_EN, a=5, b=−3 → product=8'hF1 (−15); a=−8, b=−8 → product=8'h40 (64).

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding,
// default operand width and the iteration-counter width helper.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the values WIDTH down to 0.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cladder4.sv
// 4-bit carry-lookahead adder slice with group propagate/generate outputs.
module cladder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       pg,
  output logic       gg
);

  logic [3:0] p_s;
  logic [3:0] g_s;
  logic [4:0] c_s;

  // Bit propagate/generate, lookahead carries and sum bits.
  always_comb begin
    p_s    = a ^ b;
    g_s    = a & b;
    c_s[0] = cin;
    c_s[1] = g_s[0] | (p_s[0] & cin);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);
    pg     = &p_s;
    gg     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    c_s[4] = gg | (pg & cin);
    s      = p_s ^ c_s[3:0];
    cout   = c_s[4];
  end

endmodule

// File: rtl/mul_shift_add.sv
// Sequential shift-and-add multiplier: one add/shift step per cycle through a
// ripple of cladder4 slices, valid/ready on both operand and product sides.
// Compile option MUL_SHIFT_ADD_SIGNED_EN enables two's-complement operands
// (magnitudes are multiplied, the sign is applied to the final product).
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW  = cnt_width(WIDTH);
  localparam int NSL = WIDTH / 4;

  state_t             state_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   acc_hi_r;
  logic [WIDTH-1:0]   acc_lo_r;
  logic [CW-1:0]      cnt_r;

  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   sum_s;
  logic [NSL:0]       carry_s;
  logic [WIDTH-1:0]   load_a_s;
  logic [WIDTH-1:0]   load_b_s;
  logic [2*WIDTH-1:0] raw_s;
  logic [2*WIDTH-1:0] product_s;

`ifdef MUL_SHIFT_ADD_SIGNED_EN
  logic neg_r;

  // Load magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    if (a[WIDTH-1]) begin
      load_a_s = ~a + WIDTH'(1);
    end else begin
      load_a_s = a;
    end
    if (b[WIDTH-1]) begin
      load_b_s = ~b + WIDTH'(1);
    end else begin
      load_b_s = b;
    end
  end
`else
  assign load_a_s = a;
  assign load_b_s = b;
`endif

  // Addend is the multiplicand when the current multiplier bit is set.
  always_comb begin
    if (acc_lo_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = '0;
    end
  end

  assign carry_s[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
      cladder4 u_cla (
        .a    (acc_hi_r[4*gi +: 4]),
        .b    (addend_s[4*gi +: 4]),
        .cin  (carry_s[gi]),
        .s    (sum_s[4*gi +: 4]),
        .cout (carry_s[gi+1]),
        .pg   (),
        .gg   ()
      );
    end
  endgenerate

  // Control FSM and datapath registers; DONE holds everything under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mcand_r  <= '0;
      acc_hi_r <= '0;
      acc_lo_r <= '0;
      cnt_r    <= '0;
`ifdef MUL_SHIFT_ADD_SIGNED_EN
      neg_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r  <= load_a_s;
            acc_lo_r <= load_b_s;
            acc_hi_r <= '0;
            cnt_r    <= CW'(WIDTH);
`ifdef MUL_SHIFT_ADD_SIGNED_EN
            neg_r    <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
            state_r  <= RUN;
          end
        end
        RUN: begin
          // Carry out lands in the top bit, so the shift absorbs it.
          {acc_hi_r, acc_lo_r} <= {carry_s[NSL], sum_s, acc_lo_r[WIDTH-1:1]};
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign raw_s = {acc_hi_r, acc_lo_r};

  // Product is only presented in DONE; zero elsewhere so partials never leak.
  always_comb begin
    if (state_r == DONE) begin
`ifdef MUL_SHIFT_ADD_SIGNED_EN
      if (neg_r) begin
        product_s = ~raw_s + (2*WIDTH)'(1);
      end else begin
        product_s = raw_s;
      end
`else
      product_s = raw_s;
`endif
    end else begin
      product_s = '0;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == RUN);
  assign product   = product_s;

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add (WIDTH=4): vector table, handshake
// corner sequences, and randomized operands against an arithmetic model.
module tb_mul_shift_add;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] product;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  mul_shift_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the mathematical product truncated to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
`ifdef MUL_SHIFT_ADD_SIGNED_EN
    r = int'($signed(x)) * int'($signed(y));
`else
    r = int'(x) * int'(y);
`endif
    return r[2*W-1:0];
  endfunction

  // Offer a pair (caller is just after an edge), wait for out_valid.
  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       output logic [2*W-1:0] prod, output int lat);
    bit busy_ok;
    chk("in_ready_before_offer", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    a = aa;
    b = bb;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    a = $urandom_range(0, 15);
    b = $urandom_range(0, 15);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    lat--;
    chk("busy_during_run", {15'd0, busy_ok}, 16'd1);
    chk("latency", lat[15:0], 16'(W));
    prod = product;
  endtask

  // Hold out_ready low for 'hold' cycles checking stability, then transfer.
  task automatic finish_op(input int hold, input logic [2*W-1:0] exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", {15'd0, out_valid}, 16'd1);
      chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
      chk("bp_product", {8'd0, product}, {8'd0, exp});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_xfer_in_ready", {15'd0, in_ready}, 16'd1);
    chk("post_xfer_out_valid", {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    logic [2*W-1:0] p;
    int lat;
    int c0;
    int hold;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit stale;

`ifdef MUL_SHIFT_ADD_SIGNED_EN
    tbl.push_back('{4'd5,  4'hD, 8'hF1});
    tbl.push_back('{4'h8,  4'h8, 8'h40});
    tbl.push_back('{4'd7,  4'd6, 8'h2A});
    tbl.push_back('{4'hF,  4'hF, 8'h01});
    tbl.push_back('{4'h8,  4'd7, 8'hC8});
    tbl.push_back('{4'd0,  4'h8, 8'h00});
`else
    tbl.push_back('{4'd5,  4'd3,  8'h0F});
    tbl.push_back('{4'd15, 4'd15, 8'hE1});
    tbl.push_back('{4'd7,  4'd6,  8'h2A});
    tbl.push_back('{4'd12, 4'd11, 8'h84});
    tbl.push_back('{4'd8,  4'd8,  8'h40});
    tbl.push_back('{4'd1,  4'd15, 8'h0F});
    tbl.push_back('{4'd15, 4'd1,  8'h0F});
    tbl.push_back('{4'd0,  4'd0,  8'h00});
`endif

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {15'd0, in_ready}, 16'd1);
    chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_product", {8'd0, product}, 16'd0);
    rst_n = 1'b1;

    // Table vectors with out_ready held high.
    foreach (tbl[i]) begin
      do_op(tbl[i].va, tbl[i].vb, p, lat);
      chk($sformatf("tbl%0d_product", i), {8'd0, p}, {8'd0, tbl[i].exp});
      finish_op(0, tbl[i].exp);
    end

    // Back-to-back zero products: second accept WIDTH+2 cycles after the first.
    do_op(4'd0, 4'd9, p, lat);
    c0 = acc_cyc;
    chk("b2b_first_product", {8'd0, p}, 16'd0);
    @(posedge clk);
    #1;
    do_op(4'd9, 4'd0, p, lat);
    chk("b2b_second_product", {8'd0, p}, 16'd0);
    chk("b2b_accept_spacing", 16'(acc_cyc - c0), 16'(W + 2));
    finish_op(0, 8'h00);

    // Backpressure: 5 cycles of out_ready low.
    out_ready = 1'b0;
    do_op(4'd7, 4'd6, p, lat);
    chk("bp_first_product", {8'd0, p}, 16'h2A);
    finish_op(5, 8'h2A);

    // Reset two cycles into a run discards the operation.
    in_valid = 1'b1;
    a = 4'd12;
    b = 4'd11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_product", {8'd0, product}, 16'd0);
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy || !in_ready) stale = 1'b1;
    end
    chk("midrst_no_stale", {15'd0, stale}, 16'd0);

    // Randomized operands and backpressure against the arithmetic model.
    for (int n = 0; n < 60; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      out_ready = (hold == 0);
      do_op(ra, rb, p, lat);
      chk($sformatf("rand_%0h_x_%0h", ra, rb), {8'd0, p}, {8'd0, ref_mul(ra, rb)});
      finish_op(hold, ref_mul(ra, rb));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
